// File: rtl/blackjack_pkg.sv
// Shared types for the blackjack round controller: card ranks, FSM states,
// result codes shown on state_btn, and the rank-to-points mapping.
package blackjack_pkg;

    typedef logic [3:0] rank_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DEAL,
        ST_PLAYER_TURN,
        ST_PLAYER_DRAW,
        ST_DEALER_DRAW,
        ST_RESOLVE,
        ST_DONE
    } state_e;

    localparam logic [2:0] BTN_IDLE       = 3'd0;
    localparam logic [2:0] BTN_START      = 3'd1;
    localparam logic [2:0] BTN_PLAY       = 3'd2;
    localparam logic [2:0] BTN_PLAYER_WIN = 3'd3;
    localparam logic [2:0] BTN_DEALER_WIN = 3'd4;
    localparam logic [2:0] BTN_DRAW       = 3'd5;

    function automatic logic rank_valid(rank_t r);
        return (r >= 4'd1) && (r <= 4'd13);
    endfunction

    // Aces count as 1 here; the soft +10 is applied per hand.
    function automatic logic [3:0] rank_points(rank_t r);
        if (r == 4'd0 || r > 4'd13) return 4'd0;
        if (r > 4'd10)              return 4'd10;
        return r;
    endfunction

endpackage

// File: rtl/blackjack_round_ctrl_if.sv
// Card source handshake: the controller (master) requests, the source
// (slave) presents a rank with card_valid.
interface blackjack_round_ctrl_if;
    import blackjack_pkg::*;

    logic  card_req;
    logic  card_valid;
    rank_t card_value;

    modport master (output card_req, input card_valid, input card_value);
    modport slave  (input card_req, output card_valid, output card_value);
endinterface

// File: rtl/blackjack_hand_accum.sv
// One hand: card slots filled in order, card count, and ace-aware best total.
// Optional feature: none here (soft-17 handling lives in the top).
module blackjack_hand_accum
    import blackjack_pkg::*;
#(
    parameter int MAX_CARDS  = 9,
    parameter int BUST_LIMIT = 21,
    parameter int TOT_W      = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       wr_i,
    input  rank_t                      card_i,
    output logic [MAX_CARDS-1:0][3:0]  cards_o,
    output logic [3:0]                 count_o,
    output logic [TOT_W-1:0]           total_o,
    output logic                       soft_o
);

    localparam logic [3:0] MAX_C = 4'(MAX_CARDS);

    rank_t      slot_q [MAX_CARDS];
    logic [3:0] count_q;
    logic       take;

    assign take = wr_i && (count_q < MAX_C);

    generate
        for (genvar gi = 0; gi < MAX_CARDS; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    slot_q[gi] <= '0;
                else if (clr_i)
                    slot_q[gi] <= '0;
                else if (take && count_q == 4'(gi))
                    slot_q[gi] <= card_i;
            end
            assign cards_o[gi] = slot_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else if (clr_i)
            count_q <= '0;
        else if (take)
            count_q <= count_q + 4'd1;
    end

    // The parameter check in the top guarantees sum+10 cannot wrap.
    logic [TOT_W-1:0] sum;
    logic             has_ace;

    always_comb begin
        sum     = '0;
        has_ace = 1'b0;
        for (int i = 0; i < MAX_CARDS; i++) begin
            sum = sum + TOT_W'(rank_points(slot_q[i]));
            if (slot_q[i] == 4'd1) has_ace = 1'b1;
        end
        soft_o  = has_ace && ((sum + TOT_W'(10)) <= TOT_W'(BUST_LIMIT));
        total_o = soft_o ? (sum + TOT_W'(10)) : sum;
    end

    assign count_o = count_q;

endmodule

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round controller: deals, runs the player and dealer turns, and
// resolves the result. Define BJ_SOFT17_HIT_EN to make the dealer hit soft 17.
module blackjack_round_ctrl
    import blackjack_pkg::*;
#(
    parameter int MAX_CARDS    = 9,
    parameter int DEALER_STAND = 17,
    parameter int BUST_LIMIT   = 21,
    parameter int TOT_W        = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      deal,
    input  logic                      hit,
    input  logic                      stand,
    blackjack_round_ctrl_if.master    card_bus,
    output logic [MAX_CARDS-1:0][3:0] player_cards,
    output logic [MAX_CARDS-1:0][3:0] dealer_cards,
    output logic [3:0]                player_count,
    output logic [3:0]                dealer_count,
    output logic [TOT_W-1:0]          player_total,
    output logic [TOT_W-1:0]          dealer_total,
    output logic [2:0]                state_btn,
    output logic                      round_done
);

    generate
        if (MAX_CARDS < 3 || MAX_CARDS > 12) begin : g_bad_max_cards
            $error("MAX_CARDS must be in 3..12");
        end
        if ((2 ** TOT_W) <= (MAX_CARDS * 10 + 10)) begin : g_bad_tot_w
            $error("TOT_W too narrow for MAX_CARDS");
        end
    endgenerate

    localparam logic [3:0]       MAX_C   = 4'(MAX_CARDS);
    localparam logic [TOT_W-1:0] BUST_T  = TOT_W'(BUST_LIMIT);
    localparam logic [TOT_W-1:0] STAND_T = TOT_W'(DEALER_STAND);

    state_e     state_q, state_d;
    logic [1:0] deal_idx_q, deal_idx_d;
    logic       got_q, got_d;
    logic [2:0] result_q, result_d;
    logic       armed_q;

    logic card_req, src_ok, xfer, start_ok, clr;
    logic p_wr, d_wr, p_soft, d_soft, d_low, dealer_wants;
    logic p_bust, d_bust;

    // Blocks any transition on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed_q <= 1'b0;
        else        armed_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            deal_idx_q <= '0;
            got_q      <= 1'b0;
            result_q   <= BTN_IDLE;
        end else begin
            state_q    <= state_d;
            deal_idx_q <= deal_idx_d;
            got_q      <= got_d;
            result_q   <= result_d;
        end
    end

    assign start_ok = start && armed_q;
    assign src_ok   = card_bus.card_valid && rank_valid(card_bus.card_value);
    assign xfer     = card_req && src_ok;
    assign clr      = start_ok && (state_q == ST_IDLE || state_q == ST_DONE);

    // Deal order is player, dealer, player: slot 1 of the deal goes to the dealer.
    assign p_wr = xfer && ((state_q == ST_DEAL && deal_idx_q != 2'd1) ||
                           state_q == ST_PLAYER_DRAW);
    assign d_wr = xfer && ((state_q == ST_DEAL && deal_idx_q == 2'd1) ||
                           state_q == ST_DEALER_DRAW);

`ifdef BJ_SOFT17_HIT_EN
    assign d_low = (dealer_total < STAND_T) || (dealer_total == STAND_T && d_soft);
    logic unused_soft;
    assign unused_soft = p_soft;
`else
    assign d_low = dealer_total < STAND_T;
    logic unused_soft;
    assign unused_soft = p_soft | d_soft;
`endif
    assign dealer_wants = d_low && (dealer_count < MAX_C);

    assign p_bust = player_total > BUST_T;
    assign d_bust = dealer_total > BUST_T;

    always_comb begin
        state_d    = state_q;
        deal_idx_d = deal_idx_q;
        got_d      = got_q;
        result_d   = result_q;
        card_req   = 1'b0;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_START;
            ST_START: begin
                if (deal) begin
                    state_d    = ST_DEAL;
                    deal_idx_d = '0;
                end
            end
            ST_DEAL: begin
                if (deal_idx_q != 2'd3) begin
                    card_req = 1'b1;
                    if (src_ok) deal_idx_d = deal_idx_q + 2'd1;
                end else begin
                    state_d = (player_total == BUST_T) ? ST_DEALER_DRAW : ST_PLAYER_TURN;
                end
            end
            ST_PLAYER_TURN: begin
                if (hit) begin
                    state_d = ST_PLAYER_DRAW;
                    got_d   = 1'b0;
                end else if (stand) begin
                    state_d = ST_DEALER_DRAW;
                end
            end
            ST_PLAYER_DRAW: begin
                if (!got_q) begin
                    card_req = 1'b1;
                    if (src_ok) got_d = 1'b1;
                end else if (p_bust) begin
                    state_d = ST_RESOLVE;
                end else if (player_count == MAX_C || player_total == BUST_T) begin
                    state_d = ST_DEALER_DRAW;
                end else begin
                    state_d = ST_PLAYER_TURN;
                end
            end
            ST_DEALER_DRAW: begin
                if (dealer_wants) card_req = 1'b1;
                else              state_d  = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (p_bust)                            result_d = BTN_DEALER_WIN;
                else if (d_bust)                       result_d = BTN_PLAYER_WIN;
                else if (player_total > dealer_total)  result_d = BTN_PLAYER_WIN;
                else if (player_total < dealer_total)  result_d = BTN_DEALER_WIN;
                else                                   result_d = BTN_DRAW;
                state_d = ST_DONE;
            end
            ST_DONE: if (start_ok) state_d = ST_START;
            default: state_d = ST_IDLE;
        endcase
    end

    assign card_bus.card_req = card_req;

    always_comb begin
        case (state_q)
            ST_IDLE:  state_btn = BTN_IDLE;
            ST_START: state_btn = BTN_START;
            ST_DONE:  state_btn = result_q;
            default:  state_btn = BTN_PLAY;
        endcase
    end
    assign round_done = (state_q == ST_DONE);

    blackjack_hand_accum #(
        .MAX_CARDS (MAX_CARDS),
        .BUST_LIMIT(BUST_LIMIT),
        .TOT_W     (TOT_W)
    ) u_player (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .wr_i   (p_wr),
        .card_i (card_bus.card_value),
        .cards_o(player_cards),
        .count_o(player_count),
        .total_o(player_total),
        .soft_o (p_soft)
    );

    blackjack_hand_accum #(
        .MAX_CARDS (MAX_CARDS),
        .BUST_LIMIT(BUST_LIMIT),
        .TOT_W     (TOT_W)
    ) u_dealer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .wr_i   (d_wr),
        .card_i (card_bus.card_value),
        .cards_o(dealer_cards),
        .count_o(dealer_count),
        .total_o(dealer_total),
        .soft_o (d_soft)
    );

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Directed bench for blackjack_round_ctrl: table of full rounds plus
// hand-written sequences for reset, invalid cards and the initial deal.
module tb_blackjack_round_ctrl;
    import blackjack_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, deal = 1'b0, hit = 1'b0, stand = 1'b0;
    logic [8:0][3:0] player_cards, dealer_cards;
    logic [3:0] player_count, dealer_count;
    logic [6:0] player_total, dealer_total;
    logic [2:0] state_btn;
    logic       round_done;

    blackjack_round_ctrl_if bus ();

    blackjack_round_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .deal        (deal),
        .hit         (hit),
        .stand       (stand),
        .card_bus    (bus),
        .player_cards(player_cards),
        .dealer_cards(dealer_cards),
        .player_count(player_count),
        .dealer_count(dealer_count),
        .player_total(player_total),
        .dealer_total(dealer_total),
        .state_btn   (state_btn),
        .round_done  (round_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Card source: presents the queue head, pops it once a transfer happened.
    logic [3:0] deck[$];
    bit feed_en = 1'b1;
    bit pend    = 1'b0;

    initial begin
        bus.card_valid = 1'b0;
        bus.card_value = 4'd0;
    end

    always @(negedge clk) begin
        if (feed_en) begin
            if (pend && deck.size() > 0) void'(deck.pop_front());
            if (deck.size() > 0) begin
                bus.card_valid = 1'b1;
                bus.card_value = deck[0];
            end else begin
                bus.card_valid = 1'b0;
                bus.card_value = 4'd0;
            end
            pend = bus.card_req && bus.card_valid;
        end else begin
            pend = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0: start = 1'b1;
            1: deal  = 1'b1;
            2: hit   = 1'b1;
            default: stand = 1'b1;
        endcase
        @(negedge clk);
        start = 1'b0; deal = 1'b0; hit = 1'b0; stand = 1'b0;
    endtask

    // Waits until card_req has stayed low for 3 cycles.
    task automatic wait_quiet(input string name);
        int quiet = 0;
        int cyc = 0;
        while (quiet < 3 && cyc < 400) begin
            @(negedge clk); #1;
            cyc++;
            if (!bus.card_req) quiet++;
            else               quiet = 0;
        end
        chk({name, "_settle"}, (quiet >= 3) ? 1 : 0, 1);
    endtask

    task automatic wait_req(input string name);
        int cyc = 0;
        while (!bus.card_req && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk({name, "_req"}, bus.card_req, 1);
    endtask

    typedef struct {
        logic [47:0] cards;   // first card in the most significant used nibble
        int          n;
        int          hits;
        bit          do_stand;
        int          e_pt, e_dt, e_pc, e_dc, e_btn;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{48'hA57A4,       5,  0, 1'b1, 17, 19, 2, 3, 4};
        vecs[1] = '{48'h19D8,        4,  0, 1'b0, 21, 17, 2, 2, 3};
        vecs[2] = '{48'hA769,        4,  1, 1'b0, 25,  7, 3, 1, 4};
        vecs[3] = '{48'hA69AA,       5,  0, 1'b1, 19, 26, 2, 3, 3};
        vecs[4] = '{48'hAA88,        4,  0, 1'b1, 18, 18, 2, 2, 5};
`ifdef BJ_SOFT17_HIT_EN
        vecs[5] = '{48'hA196A,       5,  0, 1'b1, 19, 17, 2, 3, 3};
`else
        vecs[5] = '{48'hA196,        4,  0, 1'b1, 19, 17, 2, 2, 3};
`endif
        vecs[6] = '{48'h5A6A7,       5,  1, 1'b0, 21, 17, 3, 2, 3};
        vecs[7] = '{48'h1A1D7,       5,  1, 1'b1, 12, 17, 3, 2, 4};
        vecs[8] = '{48'h2A222222228, 11, 7, 1'b0, 18, 18, 9, 2, 5};

        // Reset values, sampled while rst_n is held low.
        repeat (3) @(negedge clk);
        chk("rst_btn",   state_btn, BTN_IDLE);
        chk("rst_done",  round_done, 0);
        chk("rst_req",   bus.card_req, 0);
        chk("rst_ptot",  player_total, 0);
        chk("rst_dcnt",  dealer_count, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Initial deal 10,5,7 lands in the player's turn.
        pulse(0);
        chk("s1_btn_start", state_btn, BTN_START);
        deck.push_back(4'd10); deck.push_back(4'd5); deck.push_back(4'd7);
        pulse(1);
        wait_quiet("s1");
        chk("s1_ptot",  player_total, 17);
        chk("s1_dtot",  dealer_total, 5);
        chk("s1_btn",   state_btn, BTN_PLAY);
        chk("s1_state", dut.state_q, ST_PLAYER_TURN);
        chk("s1_pslot1", player_cards[1], 7);

        // Stand with an empty deck leaves the dealer waiting; reset hits mid-transfer.
        pulse(3);
        wait_req("s2");
        feed_en = 1'b0;
        @(negedge clk); #1;
        bus.card_valid = 1'b1;
        bus.card_value = 4'd9;
        #2 rst_n = 1'b0;
        #1;
        chk("s2_req_now",  bus.card_req, 0);
        chk("s2_btn_now",  state_btn, 0);
        chk("s2_ptot_now", player_total, 0);
        chk("s2_pcnt_now", player_count, 0);
        @(posedge clk); #1;
        chk("s2_dcnt",   dealer_count, 0);
        chk("s2_dtot",   dealer_total, 0);
        chk("s2_dcards", dealer_cards, 0);
        chk("s2_done",   round_done, 0);
        chk("s2_state",  dut.state_q, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        bus.card_valid = 1'b0;
        bus.card_value = 4'd0;
        feed_en = 1'b1;
        repeat (3) @(negedge clk);

        // Invalid ranks 0 and 14 are discarded while card_req stays high.
        begin
            int samples = 0;
            int lows = 0;
            int cyc = 0;
            pulse(0);
            deck.push_back(4'd0); deck.push_back(4'd14); deck.push_back(4'd3);
            deck.push_back(4'd5); deck.push_back(4'd7);
            pulse(1);
            #1;
            while (deck.size() >= 3 && cyc < 50) begin
                samples++;
                if (!bus.card_req) lows++;
                @(negedge clk); #1;
                cyc++;
            end
            chk("s3_req_low_cycles", lows, 0);
            chk("s3_samples_ge3", (samples >= 3) ? 1 : 0, 1);
        end
        wait_quiet("s3");
        chk("s3_pcnt",   player_count, 2);
        chk("s3_pslot0", player_cards[0], 3);
        chk("s3_pslot1", player_cards[1], 7);
        chk("s3_pslot2", player_cards[2], 0);
        chk("s3_ptot",   player_total, 10);
        chk("s3_dcnt",   dealer_count, 1);
        chk("s3_dtot",   dealer_total, 5);
        deck.push_back(4'd10); deck.push_back(4'd2);
        pulse(3);
        wait_quiet("s3_end");
        chk("s3_btn",  state_btn, BTN_DEALER_WIN);
        chk("s3_done", round_done, 1);

        // Full rounds from the table; each begins from DONE.
        for (int v = 0; v < 9; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            pulse(0);
            chk({tag, "_start_btn"},  state_btn, BTN_START);
            chk({tag, "_start_pcnt"}, player_count, 0);
            chk({tag, "_start_done"}, round_done, 0);
            for (int i = 0; i < vecs[v].n; i++)
                deck.push_back(vecs[v].cards[4*(vecs[v].n-1-i) +: 4]);
            pulse(1);
            wait_quiet({tag, "_deal"});
            for (int h = 0; h < vecs[v].hits; h++) begin
                pulse(2);
                wait_quiet({tag, "_hit"});
            end
            if (vecs[v].do_stand) begin
                pulse(3);
                wait_quiet({tag, "_stand"});
            end
            chk({tag, "_done"},  round_done, 1);
            chk({tag, "_btn"},   state_btn, vecs[v].e_btn);
            chk({tag, "_ptot"},  player_total, vecs[v].e_pt);
            chk({tag, "_dtot"},  dealer_total, vecs[v].e_dt);
            chk({tag, "_pcnt"},  player_count, vecs[v].e_pc);
            chk({tag, "_dcnt"},  dealer_count, vecs[v].e_dc);
            chk({tag, "_pslot0"}, player_cards[0], vecs[v].cards[4*(vecs[v].n-1) +: 4]);
            chk({tag, "_deck_used"}, deck.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
